// File: rtl/datamover_realigner_pkg.sv
// Shared types for the datamover byte realigner.
// Holds FSM state, latched job config and lane-count helper.
package datamover_package;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } realigner_state_t;

  localparam int CFG_OFF_W = 8;
  localparam int CFG_LEN_W = 32;

  // Wide enough for any supported stream/len width; narrower values zero-extend.
  typedef struct packed {
    logic [CFG_OFF_W-1:0] offset;
    logic [CFG_LEN_W-1:0] len;
  } realigner_cfg_t;

  function automatic int nb_of(input int bw);
    return bw / 8;
  endfunction

endpackage

// File: rtl/datamover_realigner_shift.sv
// Byte-lane shifter: merges the current beat with the carried tail bytes
// and produces the next carry for an offset of off bytes.
module datamover_realigner_shift
  import datamover_package::*;
#(
  parameter int BW_ALIGNED = 32
) (
  input  logic [BW_ALIGNED-1:0]   in_data,
  input  logic [BW_ALIGNED/8-1:0] in_strb,
  input  logic [BW_ALIGNED-1:0]   carry_data,
  input  logic [BW_ALIGNED/8-1:0] carry_strb,
  input  logic [CFG_OFF_W-1:0]    off,
  output logic [BW_ALIGNED-1:0]   out_data,
  output logic [BW_ALIGNED/8-1:0] out_strb,
  output logic [BW_ALIGNED-1:0]   nxt_data,
  output logic [BW_ALIGNED/8-1:0] nxt_strb
);

  localparam int NB = nb_of(BW_ALIGNED);

  always_comb begin
    out_data = '0;
    out_strb = '0;
    nxt_data = '0;
    nxt_strb = '0;
    for (int j = 0; j < NB; j++) begin
      if (j >= int'(off)) begin
        out_data[8*j +: 8] = in_data[8*(j-int'(off)) +: 8];
        out_strb[j]        = in_strb[j-int'(off)];
      end else begin
        out_data[8*j +: 8] = carry_data[8*j +: 8];
        out_strb[j]        = carry_strb[j];
        nxt_data[8*j +: 8] = in_data[8*(j+NB-int'(off)) +: 8];
        nxt_strb[j]        = in_strb[j+NB-int'(off)];
      end
    end
  end

endmodule

// File: rtl/datamover_realigner.sv
// Byte realigner between the datamover FIFO and the sink streamer.
// DATAMOVER_REALIGNER_PERF_EN adds the stall_cnt_o performance counter.
module datamover_realigner
  import datamover_package::*;
#(
  parameter int BW_ALIGNED = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [$clog2(BW_ALIGNED/8)-1:0] offset_i,
  input  logic [LEN_WIDTH-1:0]            len_i,
  output logic                            busy_o,
  output logic                            done_o,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [BW_ALIGNED-1:0]           data_in_data,
  input  logic [BW_ALIGNED/8-1:0]         data_in_strb,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic [BW_ALIGNED-1:0]           data_out_data,
  output logic [BW_ALIGNED/8-1:0]         data_out_strb
`ifdef DATAMOVER_REALIGNER_PERF_EN
  ,
  output logic [31:0]                     stall_cnt_o
`endif
);

  localparam int NB = nb_of(BW_ALIGNED);

  realigner_state_t state;
  realigner_cfg_t   cfg;

  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  cnt_nxt;
  logic [BW_ALIGNED-1:0] carry_data;
  logic [NB-1:0]         carry_strb;
  logic [BW_ALIGNED-1:0] sh_data;
  logic [NB-1:0]         sh_strb;
  logic [BW_ALIGNED-1:0] nxt_data;
  logic [NB-1:0]         nxt_strb;
  logic                  in_hs;
  logic                  last_beat;
  logic                  has_flush;

  datamover_realigner_shift #(
    .BW_ALIGNED(BW_ALIGNED)
  ) u_shift (
    .in_data   (data_in_data),
    .in_strb   (data_in_strb),
    .carry_data(carry_data),
    .carry_strb(carry_strb),
    .off       (cfg.offset),
    .out_data  (sh_data),
    .out_strb  (sh_strb),
    .nxt_data  (nxt_data),
    .nxt_strb  (nxt_strb)
  );

  assign cnt_nxt   = cnt + LEN_WIDTH'(1);
  assign last_beat = CFG_LEN_W'(cnt_nxt) == cfg.len;
  assign has_flush = cfg.offset != '0;
  assign in_hs     = (state == RUN) && data_in_valid && data_out_ready;
  assign busy_o    = (state == RUN) || (state == FLUSH);

  // RUN is a pure pass-through so the FIFO keeps holding a stalled beat.
  always_comb begin
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    data_out_data  = '0;
    data_out_strb  = '0;
    unique case (state)
      RUN: begin
        data_in_ready  = data_out_ready;
        data_out_valid = data_in_valid;
        data_out_data  = sh_data;
        data_out_strb  = sh_strb;
      end
      FLUSH: begin
        data_out_valid = 1'b1;
        data_out_data  = carry_data;
        data_out_strb  = carry_strb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cfg        <= '0;
      cnt        <= '0;
      carry_data <= '0;
      carry_strb <= '0;
      done_o     <= 1'b0;
    end else if (clear_i) begin
      state      <= IDLE;
      cfg        <= '0;
      cnt        <= '0;
      carry_data <= '0;
      carry_strb <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cfg.offset <= CFG_OFF_W'(offset_i);
            cfg.len    <= CFG_LEN_W'(len_i);
            cnt        <= '0;
            carry_data <= '0;
            carry_strb <= '0;
            if (len_i != '0) state  <= RUN;
            else             done_o <= 1'b1;
          end
        end
        RUN: begin
          if (in_hs) begin
            cnt        <= cnt_nxt;
            carry_data <= nxt_data;
            carry_strb <= nxt_strb;
            if (last_beat) begin
              if (has_flush) begin
                state <= FLUSH;
              end else begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (data_out_ready) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATAMOVER_REALIGNER_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (clear_i) begin
      stall_cnt_o <= '0;
    end else if (busy_o && data_out_valid && !data_out_ready &&
                 stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
